// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host state enum, frame constants and parity helper
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, TX_BITS, TX_ACK, RX_BITS, RECOVER} state_e;
    localparam logic [3:0] FRAME_LEN     = 4'd11;
    localparam logic [3:0] RX_LAST_BIT   = FRAME_LEN - 4'd1;
    localparam logic [3:0] TX_PARITY_BIT = 4'd8;
    localparam logic [3:0] TX_STOP_BIT   = 4'd9;
    localparam int START_IDX  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchroniser plus registered fall/rise flags for one PS/2 line
// Ports: clk, rst (sync, active-high), pad (async line in),
//        level (synchronised line), fall/rise (one-cycle edge flags, STAGES+1 cycles after pad)
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic level_q, level_d, fall_q, fall_d, rise_q, rise_d;
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], pad};
        level_d = sync_q[STAGES-1];
        fall_d  = level_q & ~sync_q[STAGES-1];
        rise_d  = ~level_q & sync_q[STAGES-1];
    end
    // Idle bus is high, so reset to 1 to avoid a false edge after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
        end
    end
    assign level = level_q;
    assign fall  = fall_q;
    assign rise  = rise_q;
endmodule

// File: rtl/ps2_host.sv
// ps2_host: PS/2 host controller, open-drain clock/data, byte transmit and optional receive
// Ports: CLOCK_50/reset (sync, active-high), PS2_CLK/PS2_DAT (open-drain, drive 0 or Z),
//        tx_data/tx_valid/tx_ready handshake, tx_done+tx_err result pulse,
//        rx_data (held), rx_valid+rx_err result pulse.
// Define PS2_RX_EN to compile in the receive path; otherwise rx outputs are 0.
module ps2_host
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);
`ifdef PS2_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif
    localparam int CYC_US      = CLK_HZ / 1_000_000;
    localparam int INHIBIT_CYC = INHIBIT_US * CYC_US;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
    localparam int RECOVER_CYC = 50 * CYC_US;
    localparam int MAX_A       = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int MAX_CYC     = MAX_A > RECOVER_CYC ? MAX_A : RECOVER_CYC;
    localparam int CW          = $clog2(MAX_CYC + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   shreg_q, shreg_d, frame;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic          tx_done_q, tx_done_d, tx_err_q, tx_err_d;
    logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          clk_lvl, clk_fall, clk_rise, dat_lvl, dat_fall, dat_rise;
    logic          active, line_act, timeout;

    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk(CLOCK_50), .rst(reset), .pad(PS2_CLK), .level(clk_lvl), .fall(clk_fall), .rise(clk_rise)
    );
    ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_dat_sync (
        .clk(CLOCK_50), .rst(reset), .pad(PS2_DAT), .level(dat_lvl), .fall(dat_fall), .rise(dat_rise)
    );

    // Any line movement restarts the gap timer while a frame is in flight
    assign active   = state_q inside {TX_BITS, TX_ACK, RX_BITS};
    assign line_act = clk_fall | clk_rise | dat_fall | dat_rise;
    assign timeout  = active && !line_act && cnt_q == CW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (active && line_act) ? '0 : cnt_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        rx_data_d  = rx_data_q;
        frame      = {dat_lvl, shreg_q[10:1]};
        if (timeout) begin
            state_d    = RECOVER;
            cnt_d      = '0;
            clk_oe_d   = 1'b0;
            dat_oe_d   = 1'b0;
            tx_done_d  = state_q != RX_BITS;
            tx_err_d   = state_q != RX_BITS;
            rx_valid_d = state_q == RX_BITS;
            rx_err_d   = state_q == RX_BITS;
        end else begin
            case (state_q)
                IDLE: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    if (tx_valid) begin
                        state_d  = INHIBIT;
                        shreg_d  = {3'b000, tx_data};
                        clk_oe_d = 1'b1;
                    end else if (RX_EN && clk_fall && !dat_lvl) begin
                        state_d = RX_BITS;
                        shreg_d = frame;
                        bit_d   = 4'd1;
                    end
                end
                // Data goes low one cycle before the clock is released, so the
                // clock is held low for exactly INHIBIT_CYC cycles in total
                INHIBIT: if (cnt_q == CW'(INHIBIT_CYC - 2)) begin
                    state_d  = RTS;
                    dat_oe_d = 1'b1;
                end
                RTS: begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = TX_BITS;
                end
                TX_BITS: if (clk_fall) begin
                    bit_d    = bit_q + 1'b1;
                    dat_oe_d = bit_q == TX_STOP_BIT ? 1'b0 :
                               bit_q == TX_PARITY_BIT ? ~odd_parity(shreg_q[7:0]) : ~shreg_q[bit_q[2:0]];
                    state_d  = bit_q == TX_STOP_BIT ? TX_ACK : TX_BITS;
                end
                TX_ACK: if (clk_fall) begin
                    tx_done_d = 1'b1;
                    tx_err_d  = dat_lvl;
                    cnt_d     = '0;
                    state_d   = RECOVER;
                end
                RX_BITS: if (clk_fall) begin
                    shreg_d = frame;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == RX_LAST_BIT) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = frame[DATA_MSB:DATA_LSB];
                        rx_err_d   = frame[START_IDX] | ~frame[STOP_IDX] |
                                     (odd_parity(frame[DATA_MSB:DATA_LSB]) != frame[PARITY_IDX]);
                        state_d    = IDLE;
                    end
                end
                RECOVER: begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    cnt_d    = (clk_lvl && dat_lvl) ? cnt_q + 1'b1 : '0;
                    if (clk_lvl && dat_lvl && cnt_q == CW'(RECOVER_CYC - 1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign PS2_CLK  = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT  = dat_oe_q ? 1'b0 : 1'bz;
    assign tx_ready = state_q == IDLE;
    assign tx_done  = tx_done_q;
    assign tx_err   = tx_err_q;
    assign rx_valid = RX_EN && rx_valid_q;
    assign rx_err   = RX_EN && rx_err_q;
    assign rx_data  = RX_EN ? rx_data_q : 8'h00;
endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host: directed self-checking bench for ps2_host with an open-drain device model
module tb_ps2_host;
    localparam int HALF        = 20;
    localparam int TIMEOUT_CYC = 1000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;
    wire ps2_clk, ps2_dat;
    pullup (ps2_clk);
    pullup (ps2_dat);
    logic dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
    assign ps2_clk = dev_clk_lo ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_lo ? 1'b0 : 1'bz;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, rx_valid, rx_err;
    logic [7:0] rx_data;
    int   n_checks = 0, n_errors = 0, done_cnt = 0, rx_cnt = 0;
    logic last_tx_err = 1'b0, last_rx_err = 1'b0;

    ps2_host #(.CLK_HZ(50_000_000), .INHIBIT_US(120), .TIMEOUT_US(20), .SYNC_STAGES(2)) dut (
        .CLOCK_50(clk), .reset(rst), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
    );

    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt++;
            last_tx_err = tx_err;
        end
        if (rx_valid) begin
            rx_cnt++;
            last_rx_err = rx_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_clk_release(output int lo);
        lo = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (ps2_clk === 1'b1) break;
            lo++;
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 4000 && tx_ready !== 1'b1; i++) @(negedge clk);
        check(tag, tx_ready, 1);
    endtask

    task automatic dev_falls(input int n);
        for (int i = 0; i < n; i++) begin
            cycles(HALF);
            dev_clk_lo = 1'b1;
            cycles(HALF);
            dev_clk_lo = 1'b0;
        end
    endtask

    task automatic dev_tx(input logic ack_low, output logic [9:0] obs);
        for (int i = 0; i < 10; i++) begin
            cycles(HALF);
            dev_clk_lo = 1'b1;
            cycles(HALF);
            obs[i] = ps2_dat;
            dev_clk_lo = 1'b0;
        end
        cycles(HALF);
        dev_dat_lo = ack_low;
        cycles(4);
        dev_clk_lo = 1'b1;
        cycles(HALF);
        dev_clk_lo = 1'b0;
        dev_dat_lo = 1'b0;
        cycles(HALF);
    endtask

    task automatic dev_send(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            dev_dat_lo = ~f[i];
            cycles(HALF);
            dev_clk_lo = 1'b1;
            cycles(HALF);
            dev_clk_lo = 1'b0;
        end
        dev_dat_lo = 1'b0;
        cycles(HALF);
    endtask

    initial begin
        int lo, d0, r0;
        logic [9:0] obs;
        cycles(5);
        rst = 1'b0;
        cycles(3);
        check("rst_ready", tx_ready, 1);
        check("rst_done", tx_done, 0);
        check("rst_txerr", tx_err, 0);
        check("rst_rxvalid", rx_valid, 0);
        check("rst_rxerr", rx_err, 0);
        check("rst_rxdata", rx_data, 8'h00);
        check("rst_clk", ps2_clk, 1);
        check("rst_dat", ps2_dat, 1);

        // 0xED with ACK; tx_data changes and tx_valid stays high during the frame
        d0 = done_cnt;
        tx_data = 8'hED;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'h00;
        wait_clk_release(lo);
        tx_valid = 1'b0;
        check("inhibit_len", lo, 6000);
        check("rts_dat", ps2_dat, 0);
        dev_tx(1'b1, obs);
        check("ed_bits", obs, 10'h3ED);
        check("ed_done", done_cnt - d0, 1);
        check("ed_err", last_tx_err, 0);
        wait_ready("ed_idle");
        check("ed_no_requeue", done_cnt - d0, 1);

        // 0xFF with no ACK
        d0 = done_cnt;
        @(negedge clk);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_clk_release(lo);
        dev_tx(1'b0, obs);
        check("ff_bits", obs, 10'h3FF);
        check("ff_done", done_cnt - d0, 1);
        check("ff_err", last_tx_err, 1);
        check("ff_recover", tx_ready, 0);
        wait_ready("ff_idle");

        // tx request in the same cycle the start edge is flagged, then reset in data bit 3
        d0 = done_cnt;
        r0 = rx_cnt;
        dev_dat_lo = 1'b1;
        cycles(HALF);
        dev_clk_lo = 1'b1;
        cycles(3);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("coll_busy", tx_ready, 0);
        dev_clk_lo = 1'b0;
        dev_dat_lo = 1'b0;
        @(negedge clk);
        check("coll_inhibit", ps2_clk, 0);
        wait_clk_release(lo);
        dev_falls(4);
        check("b3_drive", ps2_dat, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel_clk", ps2_clk, 1);
        check("rst_rel_dat", ps2_dat, 1);
        cycles(3);
        rst = 1'b0;
        cycles(TIMEOUT_CYC + 200);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_ready2", tx_ready, 1);
        check("coll_no_rx", rx_cnt - r0, 0);

`ifdef PS2_RX_EN
        r0 = rx_cnt;
        dev_send({1'b1, 1'b1, 8'hAA, 1'b0}, 11);
        check("aa_valid", rx_cnt - r0, 1);
        check("aa_err", last_rx_err, 0);
        check("aa_data", rx_data, 8'hAA);
        check("aa_idle", tx_ready, 1);
        r0 = rx_cnt;
        dev_send({1'b1, 1'b1, 8'h1C, 1'b0}, 11);
        check("1c_valid", rx_cnt - r0, 1);
        check("1c_err", last_rx_err, 1);
        check("1c_data", rx_data, 8'h1C);
        r0 = rx_cnt;
        dev_send({1'b1, 1'b1, 8'h55, 1'b0}, 4);
        check("to_early", rx_cnt - r0, 0);
        cycles(TIMEOUT_CYC + 50);
        check("to_valid", rx_cnt - r0, 1);
        check("to_err", last_rx_err, 1);
        check("to_recover", tx_ready, 0);
        wait_ready("to_idle");
`else
        r0 = rx_cnt;
        dev_send({1'b1, 1'b1, 8'hAA, 1'b0}, 5);
        check("norx_mid", tx_ready, 1);
        dev_send({5'b00000, 6'b111010}, 6);
        check("norx_valid", rx_cnt - r0, 0);
        check("norx_data", rx_data, 8'h00);
        check("norx_err", rx_err, 0);
        check("norx_idle", tx_ready, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_host.md
PS2_HOST -- requirements
Module: ps2_host

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 120, host clock-low hold time before request-to-send, in microseconds.
REQ-003 Parameter TIMEOUT_US, default 2000, maximum gap between device clock edges during a frame.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth on PS2_CLK and PS2_DAT inputs (minimum 2).
REQ-005 CLOCK_50  input  1  system clock; one clock only. Reset is synchronous and active-high.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 PS2_CLK  inout  1  open-drain PS/2 clock; the block drives only 0, otherwise high-Z.
REQ-008 PS2_DAT  inout  1  open-drain PS/2 data; the block drives only 0, otherwise high-Z.
REQ-009 tx_data  input  8  command byte to send to the device.
REQ-010 tx_valid  input  1  transmit request; the byte is accepted when tx_valid and tx_ready are both high.
REQ-011 tx_ready  output  1  high only in IDLE.
REQ-012 tx_done  output  1  one-cycle pulse at the end of a transmit; tx_err qualifies it.
REQ-013 tx_err  output  1  valid with tx_done: missing ACK or timeout.
REQ-014 rx_data  output  8  received byte, held until the next rx_valid.
REQ-015 rx_valid  output  1  one-cycle pulse when a received frame completes.
REQ-016 rx_err  output  1  valid with rx_valid: bad start, parity, stop, or timeout.

Function
REQ-017 Each line passes through ps2_sync_edge. A device falling edge on PS2_CLK is flagged SYNC_STAGES+1 cycles after the pad changes.
REQ-018 The state machine has states IDLE, INHIBIT, RTS, TX_BITS, TX_ACK, RX_BITS, and RECOVER.
REQ-019 IDLE: both lines are released.
- A tx handshake latches tx_data and moves to INHIBIT.
- Otherwise, a synchronised falling edge on PS2_CLK with PS2_DAT=0 moves to RX_BITS.
- If both occur in the same cycle, transmit wins.
REQ-020 INHIBIT: PS2_CLK is driven low for exactly INHIBIT_US*CLK_HZ/1e6 cycles. Any receive in progress is aborted without rx_valid.
REQ-021 RTS: PS2_DAT is driven low, then PS2_CLK is released after 1 cycle; the state moves to TX_BITS.
REQ-022 TX_BITS: on each device falling edge, the next bit is presented on PS2_DAT, in this order:
- 8 data bits, LSB first;
- odd parity;
- stop (released).
After the stop bit is presented, the state moves to TX_ACK.
REQ-023 TX_ACK: on the next falling edge, PS2_DAT is sampled.
- 0 gives a tx_done pulse with tx_err=0.
- 1 gives a tx_done pulse with tx_err=1.
The state then moves to RECOVER.
REQ-024 RX_BITS: PS2_DAT is sampled on each device falling edge, 11 bits in total (start, 8 data LSB first, parity, stop).
- After the 11th bit, rx_valid pulses.
- rx_err=1 if start≠0, stop≠1, or parity is not odd.
- rx_data is updated even when rx_err=1.
REQ-025 Timeout: a counter is reloaded on each device edge in TX_BITS, TX_ACK, and RX_BITS. At expiry:
- in a tx state, tx_done pulses with tx_err=1;
- in RX_BITS, rx_valid pulses with rx_err=1.
The state moves to RECOVER in both cases.
REQ-026 RECOVER: both lines are released. The state returns to IDLE once PS2_CLK and PS2_DAT have been synchronised high for 50 µs.
REQ-027 Bit counter: 4 bits wide. Parity is computed over the latched byte, not the live tx_data.
REQ-028 tx_valid outside IDLE is ignored, and is not queued.

Reset
REQ-029 On reset:
- state=IDLE;
- PS2_CLK and PS2_DAT are released;
- tx_ready=1;
- tx_done, tx_err, rx_valid, rx_err = 0;
- rx_data=8'h00;
- counters are cleared.
REQ-030 Reset mid-frame takes effect on the next edge of CLOCK_50 and releases both lines immediately. No done/valid pulse is produced.

Configuration
REQ-031 With PS2_RX_EN defined, the receive path (RX_BITS and the IDLE start detect) is compiled in.
REQ-032 Without PS2_RX_EN:
- the state stays in IDLE on device activity;
- rx_valid, rx_err, and rx_data are tied to 0;
- the transmit behaviour is identical.

Structure
REQ-033 Package ps2_pkg holds the state enum, the frame length constant (11), the bit index constants, and the odd-parity function.
REQ-034 Sub-module ps2_sync_edge holds the SYNC_STAGES synchroniser and the fall/rise edge flags for one line. It is instantiated twice.

Verification
REQ-035 Send tx_data=8'hED with a device model that ACKs. Required response:
- PS2_CLK is low for 6000 cycles;
- the bits observed are 1,0,1,1,0,1,1,1, then parity 1, then stop;
- tx_done=1 with tx_err=0.
REQ-036 Send 8'hFF with the device holding DAT high at the ACK bit. Required response: tx_done with tx_err=1, then RECOVER, then IDLE.
REQ-037 Device sends the frame 8'hAA with correct parity (1). Required response: rx_valid=1, rx_data=8'hAA, rx_err=0.
REQ-038 Device sends 8'h1C with wrong parity. Required response: rx_valid=1, rx_err=1, rx_data=8'h1C.
REQ-039 Device stops clocking after 4 bits. Required response: after 100000 idle cycles, rx_valid=1 with rx_err=1, and the state returns to IDLE.
REQ-040 Assert tx_valid in the same cycle as a device start edge. Required response: the transmit wins. Then assert reset during data bit 3: both lines are released next cycle and no tx_done pulse occurs.
